// File: rtl/chip_gate_checker.sv
// Production tester for a bank of identical logic gates: walks every input vector,
// compares each gate output against the selected function and reports pass/fail.
module chip_gate_checker #(
    parameter int GATES  = 3,
    parameter int INPUTS = 3,
    parameter int SETTLE = 1
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      Run,
    input  logic [2:0]                Func,
    output logic [GATES*INPUTS-1:0]   Drive,
    input  logic [GATES-1:0]          Sense,
    input  logic                      DISP_RSLT,
    output logic                      Done,
    output logic                      RSLT,
    output logic [GATES-1:0]          FailMask,
    output logic [INPUTS-1:0]         FailVec
);

    localparam logic [2:0] ST_HALTED = 3'd0;
    localparam logic [2:0] ST_SET    = 3'd1;
    localparam logic [2:0] ST_DRIVE  = 3'd2;
    localparam logic [2:0] ST_SAMPLE = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    localparam logic [3:0]        SETTLE_LAST = 4'(SETTLE - 1);
    localparam logic [INPUTS-1:0] VEC_LAST    = {INPUTS{1'b1}};
    localparam logic [INPUTS-1:0] VEC_ONE     = INPUTS'(1);

    function automatic logic gate_eval(input logic [2:0] fn, input logic [INPUTS-1:0] v);
        logic r;
        case (fn)
            3'd0:    r = &v;
            3'd1:    r = |v;
            3'd2:    r = ~&v;
            3'd3:    r = ~|v;
            3'd4:    r = ^v;
            3'd5:    r = ~^v;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic func_legal(input logic [2:0] fn);
        return (fn <= 3'd5);
    endfunction

    logic [2:0]        state_r;
    logic [2:0]        func_r;
    logic [INPUTS-1:0] vec_r;
    logic [3:0]        settle_r;
    logic              rslt_r;
    logic [GATES-1:0]  fail_mask_r;
    logic [INPUTS-1:0] fail_vec_r;
    logic              gate_exp_s;
    logic [GATES-1:0]  mismatch_s;

    // Expected gate output for the current vector and the per-gate mismatch bits
    always_comb begin
        gate_exp_s = gate_eval(func_r, vec_r);
        mismatch_s = Sense ^ {GATES{gate_exp_s}};
    end

    // Test sequencer: state, counters and the sticky result registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r     <= ST_HALTED;
            func_r      <= 3'd0;
            vec_r       <= '0;
            settle_r    <= 4'd0;
            rslt_r      <= 1'b0;
            fail_mask_r <= '0;
            fail_vec_r  <= '0;
        end else begin
            case (state_r)
                ST_HALTED: begin
                    if (Run) begin
                        state_r <= ST_SET;
                        func_r  <= Func;
                    end else begin
                        state_r <= ST_HALTED;
                    end
                end
                ST_SET: begin
                    vec_r      <= '0;
                    settle_r   <= 4'd0;
                    fail_vec_r <= '0;
                    if (func_legal(func_r)) begin
                        state_r     <= ST_DRIVE;
                        rslt_r      <= 1'b1;
                        fail_mask_r <= '0;
                    end else begin
                        state_r     <= ST_DONE;
                        rslt_r      <= 1'b0;
                        fail_mask_r <= '1;
                    end
                end
                ST_DRIVE: begin
                    if (settle_r == SETTLE_LAST) begin
                        state_r <= ST_SAMPLE;
                    end else begin
                        settle_r <= settle_r + 4'd1;
                    end
                end
                ST_SAMPLE: begin
                    // rslt_r still high means no mismatch has been seen since Set
                    if (|mismatch_s) begin
                        rslt_r      <= 1'b0;
                        fail_mask_r <= fail_mask_r | mismatch_s;
                        if (rslt_r) begin
                            fail_vec_r <= vec_r;
                        end
                    end
                    if (vec_r == VEC_LAST) begin
                        state_r <= ST_DONE;
                    end else begin
                        vec_r    <= vec_r + VEC_ONE;
                        settle_r <= 4'd0;
                        state_r  <= ST_DRIVE;
                    end
                end
                ST_DONE: begin
                    if (DISP_RSLT) begin
                        state_r <= ST_HALTED;
                    end else begin
                        state_r <= ST_DONE;
                    end
                end
                default: state_r <= ST_HALTED;
            endcase
        end
    end

    // Pin drive and completion flag decode the current state
    always_comb begin
        Drive = '0;
        Done  = 1'b0;
        if (state_r == ST_DRIVE || state_r == ST_SAMPLE) begin
            Drive = {GATES{vec_r}};
        end else begin
            Drive = '0;
        end
        if (state_r == ST_DONE) begin
            Done = 1'b1;
        end else begin
            Done = 1'b0;
        end
    end

    assign RSLT     = rslt_r;
    assign FailMask = fail_mask_r;
    assign FailVec  = fail_vec_r;

endmodule

// File: tb/tb_chip_gate_checker.sv
// Bench for chip_gate_checker: a fault-injectable gate bank answers on Sense and a
// vector-by-vector reference model predicts the verdict of every run.
module tb_chip_gate_checker;

    localparam int GATES  = 3;
    localparam int INPUTS = 3;
    localparam int SETTLE = 1;
    localparam int NVEC   = 1 << INPUTS;

    logic                    Clk = 1'b0;
    logic                    Reset;
    logic                    Run;
    logic [2:0]              Func;
    logic [GATES*INPUTS-1:0] Drive;
    logic [GATES-1:0]        Sense;
    logic                    DISP_RSLT;
    logic                    Done;
    logic                    RSLT;
    logic [GATES-1:0]        FailMask;
    logic [INPUTS-1:0]       FailVec;

    int checks = 0;
    int passes = 0;

    logic [GATES-1:0] stuck0 = '0;
    logic [GATES-1:0] stuck1 = '0;
    bit               flip_en = 1'b0;
    int               flip_gate = 0;
    int               flip_vec = 0;
    int               cur_func = 0;

    always #5 Clk = ~Clk;

    chip_gate_checker #(.GATES(GATES), .INPUTS(INPUTS), .SETTLE(SETTLE)) dut (
        .Clk(Clk), .Reset(Reset), .Run(Run), .Func(Func), .Drive(Drive),
        .Sense(Sense), .DISP_RSLT(DISP_RSLT), .Done(Done), .RSLT(RSLT),
        .FailMask(FailMask), .FailVec(FailVec)
    );

    function automatic bit ideal_out(input int fn, input int v);
        int ones;
        ones = 0;
        for (int i = 0; i < INPUTS; i++) ones += (v >> i) & 1;
        case (fn)
            0:       return ones == INPUTS;
            1:       return ones > 0;
            2:       return ones != INPUTS;
            3:       return ones == 0;
            4:       return (ones % 2) == 1;
            5:       return (ones % 2) == 0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit faulty_out(input int g, input int fn, input int v,
                                      input logic [GATES-1:0] s0, input logic [GATES-1:0] s1,
                                      input bit fe, input int fg, input int fv);
        if (s1[g]) return 1'b1;
        if (s0[g]) return 1'b0;
        return ideal_out(fn, v) ^ (fe && fg == g && fv == v);
    endfunction

    // Device under test: each gate looks only at its own slice of Drive
    always_comb begin
        Sense = '0;
        for (int g = 0; g < GATES; g++)
            Sense[g] = faulty_out(g, cur_func, int'(Drive[g*INPUTS +: INPUTS]),
                                  stuck0, stuck1, flip_en, flip_gate, flip_vec);
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic compute_expected(input int fn, output logic r, output logic [GATES-1:0] m,
                                    output logic [INPUTS-1:0] fv);
        m  = '0;
        fv = '0;
        if (fn > 5) begin
            r = 1'b0;
            m = '1;
        end else begin
            for (int v = 0; v < NVEC; v++)
                for (int g = 0; g < GATES; g++)
                    if (faulty_out(g, fn, v, stuck0, stuck1, flip_en, flip_gate, flip_vec) != ideal_out(fn, v)) begin
                        if (m == '0) fv = INPUTS'(v);
                        m[g] = 1'b1;
                    end
            r = (m == '0);
        end
    endtask

    task automatic start_run(input int fn);
        cur_func = fn;
        Func = 3'(fn);
        Run = 1'b1;
        tick();
        Run = 1'b0;
        Func = 3'($urandom_range(0, 7));
    endtask

    task automatic check_results(input string name, input logic r, input logic [GATES-1:0] m,
                                 input logic [INPUTS-1:0] fv);
        checks++;
        if (RSLT !== r || FailMask !== m || FailVec !== fv)
            $display("FAIL %s results: got rslt=%b mask=%b vec=%b want rslt=%b mask=%b vec=%b",
                     name, RSLT, FailMask, FailVec, r, m, fv);
        else passes++;
    endtask

    task automatic run_and_check(input string name, input int fn, input logic r,
                                 input logic [GATES-1:0] m, input logic [INPUTS-1:0] fv,
                                 input int hold, input bit noise);
        logic [INPUTS-1:0]       v;
        logic [GATES*INPUTS-1:0] exp_drive;
        start_run(fn);
        checks++;
        if (Drive !== '0 || Done !== 1'b0)
            $display("FAIL %s set: got drive=%b done=%b want drive=0 done=0", name, Drive, Done);
        else passes++;
        if (fn <= 5) begin
            for (int j = 0; j < NVEC * (SETTLE + 1); j++) begin
                if (noise) begin
                    Run = 1'($urandom_range(0, 1));
                    DISP_RSLT = 1'($urandom_range(0, 1));
                end
                tick();
                v = INPUTS'(j / (SETTLE + 1));
                exp_drive = {GATES{v}};
                checks++;
                if (Drive !== exp_drive || Done !== 1'b0)
                    $display("FAIL %s walk%0d: got drive=%b done=%b want drive=%b done=0",
                             name, j, Drive, Done, exp_drive);
                else passes++;
            end
            Run = 1'b0;
            DISP_RSLT = 1'b0;
        end
        tick();
        checks++;
        if (Done !== 1'b1 || Drive !== '0)
            $display("FAIL %s done: got done=%b drive=%b want done=1 drive=0", name, Done, Drive);
        else passes++;
        check_results(name, r, m, fv);
        for (int h = 0; h < hold; h++) begin
            Run = 1'($urandom_range(0, 1));
            tick();
            checks++;
            if (Done !== 1'b1)
                $display("FAIL %s hold%0d: got done=%b want done=1", name, h, Done);
            else passes++;
        end
        Run = 1'b0;
        DISP_RSLT = 1'b1;
        tick();
        DISP_RSLT = 1'b0;
        checks++;
        if (Done !== 1'b0 || Drive !== '0)
            $display("FAIL %s ack: got done=%b drive=%b want done=0 drive=0", name, Done, Drive);
        else passes++;
        check_results({name, "_kept"}, r, m, fv);
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if (Done !== 1'b0 || Drive !== '0 || RSLT !== 1'b0 || FailMask !== '0 || FailVec !== '0)
            $display("FAIL %s: got done=%b drive=%b rslt=%b mask=%b vec=%b want all 0",
                     name, Done, Drive, RSLT, FailMask, FailVec);
        else passes++;
    endtask

    task automatic test_reset();
        Reset = 1'b1; Run = 1'b1; Func = 3'd0; DISP_RSLT = 1'b0;
        tick();
        tick();
        check_all_zero("reset");
        Reset = 1'b0; Run = 1'b0;
        tick();
        check_all_zero("reset_idle");
    endtask

    task automatic test_nor_ideal();
        stuck0 = '0; stuck1 = '0; flip_en = 1'b0;
        run_and_check("nor_ideal", 3, 1'b1, 3'b000, 3'b000, 2, 1'b0);
    endtask

    task automatic test_stuck();
        stuck0 = 3'b010; stuck1 = 3'b000;
        run_and_check("nor_s1_0", 3, 1'b0, 3'b010, 3'b000, 1, 1'b0);
        stuck0 = 3'b000; stuck1 = 3'b100;
        run_and_check("and_s2_1", 0, 1'b0, 3'b100, 3'b000, 0, 1'b0);
        stuck0 = 3'b100; stuck1 = 3'b000;
        run_and_check("and_s2_0", 0, 1'b0, 3'b100, 3'b111, 0, 1'b0);
        stuck0 = '0;
    endtask

    task automatic test_illegal();
        run_and_check("illegal6", 6, 1'b0, 3'b111, 3'b000, 1, 1'b0);
        run_and_check("illegal7", 7, 1'b0, 3'b111, 3'b000, 0, 1'b1);
    endtask

    task automatic test_reset_mid();
        logic [INPUTS-1:0] v4;
        v4 = 3'd4;
        stuck0 = '0; stuck1 = '0; flip_en = 1'b0;
        start_run(3);
        for (int j = 0; j < 9; j++) tick();
        checks++;
        if (Drive !== {GATES{v4}})
            $display("FAIL mid_vec4: got drive=%b want %b", Drive, {GATES{v4}});
        else passes++;
        Reset = 1'b1; Run = 1'b1;
        tick();
        Reset = 1'b0; Run = 1'b0;
        check_all_zero("reset_mid");
        tick();
        check_all_zero("reset_mid_idle");
        run_and_check("after_reset", 1, 1'b1, 3'b000, 3'b000, 0, 1'b1);
        start_run(6);
        tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check_all_zero("reset_done");
    endtask

    task automatic test_done_hold();
        run_and_check("done_hold", 5, 1'b1, 3'b000, 3'b000, 10, 1'b1);
        stuck1 = 3'b001;
        run_and_check("done_hold_fail", 4, 1'b0, 3'b001, 3'b000, 10, 1'b1);
        stuck1 = '0;
    endtask

    task automatic test_random();
        logic              r;
        logic [GATES-1:0]  m;
        logic [INPUTS-1:0] fv;
        int                fn;
        for (int it = 0; it < 24; it++) begin
            fn = int'($urandom_range(0, 7));
            stuck0 = ($urandom_range(0, 3) == 0) ? GATES'($urandom) : '0;
            stuck1 = ($urandom_range(0, 3) == 0) ? (GATES'($urandom) & ~stuck0) : '0;
            flip_en = 1'($urandom_range(0, 1));
            flip_gate = int'($urandom_range(0, GATES - 1));
            flip_vec = int'($urandom_range(0, NVEC - 1));
            compute_expected(fn, r, m, fv);
            run_and_check($sformatf("rand%0d_f%0d", it, fn), fn, r, m, fv,
                          int'($urandom_range(0, 3)), 1'b1);
        end
        stuck0 = '0; stuck1 = '0; flip_en = 1'b0;
    endtask

    initial begin
        Reset = 1'b1; Run = 1'b0; Func = 3'd0; DISP_RSLT = 1'b0;
        test_reset();
        test_nor_ideal();
        test_stuck();
        test_illegal();
        test_reset_mid();
        test_done_hold();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
